// File: rtl/arm_pkg.sv
// Shared definitions for the ARM multicycle controller: condition-code
// encodings and NZCV flag bit positions.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether an instruction with
// condition field Cond executes given the architectural NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic ge;

  assign flag_n = Flags[FLAG_N];
  assign flag_z = Flags[FLAG_Z];
  assign flag_c = Flags[FLAG_C];
  assign flag_v = Flags[FLAG_V];
  assign ge     = (flag_n == flag_v);

  always_comb begin
    // NOTE: default assigned first so every path drives CondEx and no latch is inferred.
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = flag_z;
      COND_NE: CondEx = ~flag_z;
      COND_CS: CondEx = flag_c;
      COND_CC: CondEx = ~flag_c;
      COND_MI: CondEx = flag_n;
      COND_PL: CondEx = ~flag_n;
      COND_VS: CondEx = flag_v;
      COND_VC: CondEx = ~flag_v;
      COND_HI: CondEx = flag_c & ~flag_z;
      COND_LS: CondEx = ~flag_c | flag_z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~flag_z & ge;
      COND_LE: CondEx = flag_z | ~ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field and
// gates the FSM's write requests into the final register/memory/PC enables.
module cond_unit
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic       cond_ex;
  logic       cond_ex_delayed;
  logic [1:0] flag_write;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  assign flag_write = FlagW & {2{cond_ex}};

  // The write decision is taken in EXECUTE on the old flags and used one
  // cycle later, so flags updated at the end of EXECUTE cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags           <= '0;
      cond_ex_delayed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (flag_write[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      cond_ex_delayed <= cond_ex;
    end
  end

  // NextPC is never gated so fetch always advances.
  assign RegWrite = RegW & cond_ex_delayed;
  assign MemWrite = MemW & cond_ex_delayed;
  assign PCWrite  = NextPC | (PCS & cond_ex_delayed);

endmodule
